// File: rtl/param_memory.sv
// Parametrised single-clock RAM with byte-enable writes, registered read port,
// selectable read-during-write policy and a one-word-per-cycle clear engine.
module param_memory #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter bit WRITE_FIRST = 1'b0
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Clear,
    input  logic                    Write_Enable,
    input  logic [DATA_WIDTH/8-1:0] Byte_Enable,
    input  logic [ADDR_WIDTH-1:0]   Write_Address,
    input  logic [DATA_WIDTH-1:0]   Write_Data,
    input  logic                    Read_Enable,
    input  logic [ADDR_WIDTH-1:0]   Read_Address,
    output logic [DATA_WIDTH-1:0]   Read_Data,
    output logic                    Read_Valid,
    output logic                    Busy,
    output logic                    Drop
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_acc_p0, rd_acc_p0, clr_wr_p0;
    logic                  mem_we_p0;
    logic [ADDR_WIDTH-1:0] mem_addr_p0;
    logic [NB-1:0]         mem_be_p0;
    logic [DATA_WIDTH-1:0] mem_wd_p0;

    logic [DATA_WIDTH-1:0] rd_raw_p1;
    logic [NB-1:0]         byp_mask_p1;
    logic [DATA_WIDTH-1:0] byp_data_p1;
    logic                  rd_zero_p1;
    logic                  vld_p1;
    logic                  drop_p1;

    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] upd,
        input logic [NB-1:0]         mask
    );
        logic [DATA_WIDTH-1:0] r;
        r = base;
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) r[8*i +: 8] = upd[8*i +: 8];
        end
        return r;
    endfunction

    // Stage p0: request acceptance and write-port arbitration (clear engine vs user)
    always_comb begin
        wr_acc_p0   = !Reset && (state_q == ST_IDLE) && Write_Enable;
        rd_acc_p0   = !Reset && (state_q == ST_IDLE) && Read_Enable;
        clr_wr_p0   = !Reset && (state_q == ST_CLEAR);
        mem_we_p0   = wr_acc_p0 || clr_wr_p0;
        mem_addr_p0 = clr_wr_p0 ? clr_ptr_q : Write_Address;
        mem_be_p0   = clr_wr_p0 ? {NB{1'b1}} : Byte_Enable;
        mem_wd_p0   = clr_wr_p0 ? '0 : Write_Data;
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (&clr_ptr_q) state_d = ST_IDLE;
            end
            default: begin
                if (Clear) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
        endcase
    end

    // Block-RAM style array: read-first behaviour falls out of the single process
    always_ff @(posedge Clock) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we_p0 && mem_be_p0[i]) mem[mem_addr_p0][8*i +: 8] <= mem_wd_p0[8*i +: 8];
        end
        if (rd_acc_p0) rd_raw_p1 <= mem[Read_Address];
    end

    // Compare-and-merge bypass: overlays freshly written bytes onto the old word
    always_ff @(posedge Clock) begin
        if (rd_acc_p0) begin
            byp_mask_p1 <= (WRITE_FIRST && wr_acc_p0 && (Write_Address == Read_Address))
                           ? Byte_Enable : '0;
            byp_data_p1 <= Write_Data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            vld_p1     <= 1'b0;
            drop_p1    <= 1'b0;
            rd_zero_p1 <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            vld_p1    <= rd_acc_p0;
            drop_p1   <= (state_q == ST_CLEAR) && (Write_Enable || Read_Enable);
            if (rd_acc_p0) rd_zero_p1 <= 1'b0;
        end
    end

    // Stage p1: output word
    always_comb begin
        Read_Data = byte_merge(rd_raw_p1, byp_data_p1, byp_mask_p1);
        if (rd_zero_p1) Read_Data = '0;
    end

    assign Read_Valid = vld_p1;
    assign Drop       = drop_p1;
    assign Busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_param_memory.sv
// Randomised scoreboard bench for param_memory: read-first and write-first
// instances share one stimulus stream and are checked against an array model.
module tb_param_memory;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        Reset = 1'b1, Clear = 1'b0, Write_Enable = 1'b0, Read_Enable = 1'b0;
    logic [1:0]  Byte_Enable = 2'b00;
    logic [3:0]  Write_Address = '0, Read_Address = '0;
    logic [15:0] Write_Data = '0;

    logic [15:0] rd_rf, rd_wf;
    logic        vld_rf, vld_wf, busy_rf, busy_wf, drop_rf, drop_wf;

    param_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_FIRST(1'b0)) u_rf (
        .Clock(clk), .Reset(Reset), .Clear(Clear), .Write_Enable(Write_Enable),
        .Byte_Enable(Byte_Enable), .Write_Address(Write_Address), .Write_Data(Write_Data),
        .Read_Enable(Read_Enable), .Read_Address(Read_Address), .Read_Data(rd_rf),
        .Read_Valid(vld_rf), .Busy(busy_rf), .Drop(drop_rf));

    param_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_FIRST(1'b1)) u_wf (
        .Clock(clk), .Reset(Reset), .Clear(Clear), .Write_Enable(Write_Enable),
        .Byte_Enable(Byte_Enable), .Write_Address(Write_Address), .Write_Data(Write_Data),
        .Read_Enable(Read_Enable), .Read_Address(Read_Address), .Read_Data(rd_wf),
        .Read_Valid(vld_wf), .Busy(busy_wf), .Drop(drop_wf));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        int          due;
    } exp_t;

    exp_t        q_rf[$];
    exp_t        q_wf[$];
    logic [15:0] mem_m [DEPTH];
    int          busy_left = 0;
    bit          busy_m = 1'b0, drop_m = 1'b0, chk_en = 1'b0;
    logic [15:0] held_rf = '0, held_wf = '0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: abstract memory plus a busy countdown; drives one edge of stimulus
    task automatic drive(input bit rst, input bit clr, input bit we, input logic [1:0] be,
                         input logic [3:0] wa, input logic [15:0] wd,
                         input bit re, input logic [3:0] ra);
        logic [15:0] old;
        @(negedge clk);
        Reset = rst; Clear = clr; Write_Enable = we; Byte_Enable = be;
        Write_Address = wa; Write_Data = wd; Read_Enable = re; Read_Address = ra;
        if (rst) begin
            busy_m = 1'b1; busy_left = DEPTH; drop_m = 1'b0;
            held_rf = '0; held_wf = '0;
        end else if (busy_m) begin
            drop_m = we || re;
            busy_left--;
            if (busy_left == 0) begin
                busy_m = 1'b0;
                for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            end
        end else begin
            drop_m = 1'b0;
            old = mem_m[ra];
            if (we) begin
                for (int b = 0; b < 2; b++)
                    if (be[b]) mem_m[wa][8*b +: 8] = wd[8*b +: 8];
            end
            if (re) begin
                q_rf.push_back('{d: old, due: cyc + 1});
                q_wf.push_back('{d: mem_m[ra], due: cyc + 1});
                held_rf = old;
                held_wf = mem_m[ra];
            end
            if (clr) begin
                busy_m = 1'b1; busy_left = DEPTH;
            end
        end
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 2'b00, 4'd0, 16'h0, 0, 4'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        drive(0, 0, 1, be, a, d, 0, 4'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        drive(0, 0, 0, 2'b00, 4'd0, 16'h0, 1, a);
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        bit exp_v;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                chk("busy_rf", busy_rf, busy_m);
                chk("busy_wf", busy_wf, busy_m);
                chk("drop_rf", drop_rf, drop_m);
                chk("drop_wf", drop_wf, drop_m);
                chk("hold_rf", rd_rf, held_rf);
                chk("hold_wf", rd_wf, held_wf);

                while (q_rf.size() > 0 && q_rf[0].due < cyc) void'(q_rf.pop_front());
                exp_v = (q_rf.size() > 0) && (q_rf[0].due == cyc);
                chk("valid_rf", vld_rf, exp_v);
                if (exp_v) begin
                    e = q_rf.pop_front();
                    if (vld_rf) chk("rdata_rf", rd_rf, e.d);
                end

                while (q_wf.size() > 0 && q_wf[0].due < cyc) void'(q_wf.pop_front());
                exp_v = (q_wf.size() > 0) && (q_wf[0].due == cyc);
                chk("valid_wf", vld_wf, exp_v);
                if (exp_v) begin
                    e = q_wf.pop_front();
                    if (vld_wf) chk("rdata_wf", rd_wf, e.d);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        // reset and power-up clear, then back-to-back reads of every word
        drive(1, 0, 0, 2'b00, 4'd0, 16'h0, 0, 4'd0);
        idle(DEPTH);
        for (int a = 0; a < DEPTH; a++) rd(4'(a));
        idle(1);

        // write then read latency
        wr(4'd3, 16'hBEEF, 2'b11);
        rd(4'd3);
        idle(1);

        // byte enable merge
        wr(4'd5, 16'h1234, 2'b11);
        wr(4'd5, 16'hABCD, 2'b10);
        rd(4'd5);
        wr(4'd6, 16'h7777, 2'b00);
        rd(4'd6);
        idle(1);

        // read during write, same address and different address
        wr(4'd7, 16'h1111, 2'b11);
        drive(0, 0, 1, 2'b11, 4'd7, 16'h2222, 1, 4'd7);
        drive(0, 0, 1, 2'b01, 4'd7, 16'h5A5A, 1, 4'd7);
        drive(0, 0, 1, 2'b11, 4'd8, 16'h3333, 1, 4'd7);
        idle(1);

        // clear from idle, with a write dropped at the 4th busy cycle
        for (int a = 0; a < DEPTH; a++) wr(4'(a), 16'h0F00 + 16'(a), 2'b11);
        drive(0, 1, 1, 2'b11, 4'd1, 16'hCAFE, 1, 4'd1);
        for (int k = 0; k < 20; k++)
            drive(0, (k == 5), (k == 3), 2'b11, 4'd2, 16'h5555, (k == 7), 4'd2);
        for (int a = 0; a < DEPTH; a++) rd(4'(a));

        // reset in the middle of a clear
        for (int a = 0; a < DEPTH; a++) wr(4'(a), 16'hA500 + 16'(a), 2'b11);
        drive(0, 1, 0, 2'b00, 4'd0, 16'h0, 0, 4'd0);
        idle(9);
        drive(1, 0, 0, 2'b00, 4'd0, 16'h0, 0, 4'd0);
        idle(DEPTH + 2);
        for (int a = 0; a < DEPTH; a++) rd(4'(a));

        // randomised traffic
        for (int k = 0; k < 800; k++) begin
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 16'($urandom),
                  ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));
        end

        idle(3);
        @(posedge clk);
        #2;
        chk("pending_rf", q_rf.size(), 0);
        chk("pending_wf", q_wf.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
